// File: rtl/pkt_rr_mux_if.sv
// Packet bus bundle for the round-robin packet aggregator.
// Per-port input streams on one side, a single tagged output stream on the other.
interface pkt_rr_mux_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 134,
  parameter int CNT_W     = 16
);
  localparam int PW = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [PW-1:0]               out_port;
  logic [NUM_PORTS*CNT_W-1:0]  drop_cnt;
  logic                        busy;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, out_port, drop_cnt, busy
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, out_port, drop_cnt, busy
  );
endinterface

// File: rtl/pkt_rr_mux.sv
// N-port store-and-forward packet aggregator with per-port buffers
// and round-robin arbitration at packet boundaries.
module pkt_rr_mux #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 134,
  parameter int FIFO_AW   = 6,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  pkt_rr_mux_if.slave bus
);
  localparam int PW    = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PTR_W = FIFO_AW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [DATA_W-1:0] r_mem [NUM_PORTS][DEPTH];
  logic [DEPTH-1:0]  r_tl  [NUM_PORTS];
  logic [PTR_W-1:0]  r_wr_ptr  [NUM_PORTS];
  logic [PTR_W-1:0]  r_cm_ptr  [NUM_PORTS];
  logic [PTR_W-1:0]  r_rd_ptr  [NUM_PORTS];
  logic [PTR_W-1:0]  r_pkt_cnt [NUM_PORTS];
  logic [CNT_W-1:0]  r_drop    [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_in_pkt;

  state_t            r_state;
  logic [PW-1:0]     r_grant;
  logic [PW-1:0]     r_rr_last;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [PW-1:0]     r_out_port;
  logic              r_busy;

  logic [DATA_W-1:0] w_word [NUM_PORTS];
  logic [PTR_W-1:0]  w_base    [NUM_PORTS];
  logic [PTR_W-1:0]  w_wr_nxt  [NUM_PORTS];
  logic [PTR_W-1:0]  w_cm_nxt  [NUM_PORTS];
  logic [PTR_W-1:0]  w_cnt_nxt [NUM_PORTS];
  logic [CNT_W:0]    w_sum     [NUM_PORTS];
  logic [CNT_W-1:0]  w_drop_nxt[NUM_PORTS];
  logic [NUM_PORTS-1:0] w_hd;
  logic [NUM_PORTS-1:0] w_tl;
  logic [NUM_PORTS-1:0] w_take;
  logic [NUM_PORTS-1:0] w_trunc;
  logic [NUM_PORTS-1:0] w_ovf;
  logic [NUM_PORTS-1:0] w_we;
  logic [NUM_PORTS-1:0] w_commit;
  logic [NUM_PORTS-1:0] w_rd;
  logic [NUM_PORTS-1:0] w_rd_tail;

  logic [FIFO_AW-1:0] w_rd_addr;
  logic               w_rd_tl;
  logic               w_send;
  logic               w_any;
  logic [PW-1:0]      w_pick;

  assign w_send    = (r_state == S_SEND);
  assign w_rd_addr = r_rd_ptr[r_grant][FIFO_AW-1:0];
  assign w_rd_tl   = r_tl[r_grant][w_rd_addr];

  // A head always restarts at commit_ptr, so occupancy is judged there.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_word[p]  = bus.in_data[p*DATA_W +: DATA_W];
      w_hd[p]    = w_word[p][DATA_W-2];
      w_tl[p]    = w_word[p][DATA_W-1];
      w_base[p]  = w_hd[p] ? r_cm_ptr[p] : r_wr_ptr[p];
      w_take[p]  = bus.in_valid[p] & (w_hd[p] | r_in_pkt[p]);
      w_trunc[p] = bus.in_valid[p] & w_hd[p] & r_in_pkt[p];
      w_ovf[p]   = w_take[p] &
                   ((w_base[p] - r_rd_ptr[p]) == PTR_W'(DEPTH));
      w_we[p]     = w_take[p] & ~w_ovf[p];
      w_commit[p] = w_we[p] & w_tl[p];
      w_rd[p]      = w_send & (r_grant == PW'(p));
      w_rd_tail[p] = w_rd[p] & w_rd_tl;
      w_wr_nxt[p] = w_we[p]   ? w_base[p] + 1'b1 :
                    w_take[p] ? r_cm_ptr[p] : r_wr_ptr[p];
      w_cm_nxt[p] = w_commit[p] ? w_base[p] + 1'b1 : r_cm_ptr[p];
      w_cnt_nxt[p] = r_pkt_cnt[p] + PTR_W'(w_commit[p])
                     - PTR_W'(w_rd_tail[p]);
      w_sum[p] = {1'b0, r_drop[p]} + (CNT_W+1)'(w_trunc[p])
                 + (CNT_W+1)'(w_ovf[p]);
      w_drop_nxt[p] = w_sum[p][CNT_W] ? '1 : w_sum[p][CNT_W-1:0];
    end
  end

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!w_any &&
          r_pkt_cnt[(int'(r_rr_last) + i) % NUM_PORTS] != '0) begin
        w_any  = 1'b1;
        w_pick = PW'((int'(r_rr_last) + i) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_we[p]) begin
        r_mem[p][w_base[p][FIFO_AW-1:0]] <= w_word[p];
        r_tl[p][w_base[p][FIFO_AW-1:0]]  <= w_tl[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wr_ptr[p]  <= '0;
        r_cm_ptr[p]  <= '0;
        r_rd_ptr[p]  <= '0;
        r_pkt_cnt[p] <= '0;
        r_drop[p]    <= '0;
      end
      r_in_pkt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_wr_ptr[p]  <= w_wr_nxt[p];
        r_cm_ptr[p]  <= w_cm_nxt[p];
        r_rd_ptr[p]  <= r_rd_ptr[p] + PTR_W'(w_rd[p]);
        r_pkt_cnt[p] <= w_cnt_nxt[p];
        r_drop[p]    <= w_drop_nxt[p];
        if (w_take[p])
          r_in_pkt[p] <= w_we[p] & ~w_tl[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_last   <= PW'(NUM_PORTS - 1);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          if (w_any) begin
            r_grant   <= w_pick;
            r_rr_last <= w_pick;
            r_state   <= S_SEND;
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_mem[r_grant][w_rd_addr];
          r_out_port  <= r_grant;
          if (w_rd_tl) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_port  = r_out_port;
  assign bus.busy      = r_busy;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_drop
    assign bus.drop_cnt[g*CNT_W +: CNT_W] = r_drop[g];
  end
endmodule
